ascon_rr_sched: RTL and testbench
=================================

Name: ascon_rr_sched

Overview:
- Round-robin scheduler that shares one ascon_top core between two requesters (ports 0/1).
- Arbitrates job requests, latches the winner's key, nonce, sizes and delay into the core's parameter inputs, and pulses start.
- Returns the tag plus a done or error pulse to the owning requester and supervises each job with a watchdog.
- Drives sel_o so the integration muxes the AD/PT/CT FIFO paths to the granted requester.

Parameters:
DataAddrWidth, 7, width of ad_size/pt_size block counts
DelayWidth, 16, width of inter-round delay value
WdogWidth, 20, width of watchdog counter
WdogCycles, 20'hFFFFF, cycles allowed from start to tag_valid before abort

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  2  per-requester job request, level, held until done/err
key0_i, key1_i  in  128 each  requester keys
nonce0_i, nonce1_i  in  128 each  requester nonces
ad_size0_i, ad_size1_i  in  DataAddrWidth each  AD block counts
pt_size0_i, pt_size1_i  in  DataAddrWidth each  PT block counts
delay0_i, delay1_i  in  DelayWidth each  round delays
gnt_o  out  2  one-hot grant, held for whole job
done_o  out  2  one-cycle job-complete pulse to owner
err_o  out  2  one-cycle watchdog-abort pulse to owner
tag_o  out  128  registered tag, valid while done_o pulses
sel_o  out  1  granted requester index (FIFO mux select)
core_key_o  out  128  to ascon_top key_i
core_nonce_o  out  128  to ascon_top nonce_i
core_ad_size_o  out  DataAddrWidth  to ascon_top ad_size_i
core_pt_size_o  out  DataAddrWidth  to ascon_top pt_size_i
core_delay_o  out  DelayWidth  to ascon_top delay_i
core_start_o  out  1  to ascon_top start_i
core_ready_i  in  1  from ascon_top ready_o
core_tag_valid_i  in  1  from ascon_top tag_valid_o
core_tag_i  in  128  from ascon_top tag_o
core_abort_o  out  1  one-cycle pulse; integration ORs it into the core/FIFO reset

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, round-robin pointer last=1 so requester 0 has first priority.
  - Watchdog 0.
- FSM states: IDLE, START, BUSY, DONE, ABORT.
- IDLE:
  - When core_ready_i=1 and req_i!=0, pick the winner: if both requesters are active, the winner is the one that is not `last`; otherwise the sole active one.
  - Same cycle: register the winner's key/nonce/sizes/delay into core_*_o, set gnt_o one-hot, set sel_o=winner, set last=winner. Go to START.
  - If core_ready_i=0, wait; no grant.
- START:
  - core_start_o=1 for exactly one cycle. Parameters are already stable one cycle before start.
  - Clear the watchdog, go to BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - core_tag_valid_i=1: capture core_tag_i into tag_o, pulse done_o[owner] next cycle, go to DONE.
  - Watchdog == WdogCycles-1 without tag_valid: go to ABORT.
  - If tag_valid and watchdog expiry coincide, tag_valid wins (done, no err).
- DONE:
  - done_o pulse, then gnt_o cleared.
  - Wait until core_tag_valid_i=0 and core_ready_i=1, then go to IDLE.
  - tag_o holds its value until the next capture.
- ABORT:
  - One cycle: core_abort_o=1, err_o[owner]=1, gnt_o cleared, tag_o unchanged.
  - Then go to IDLE; re-arbitration waits for core_ready_i.
- Requester rules:
  - Deassertion of req_i after grant is ignored; the job runs to done/err.
  - The requester must drop req_i within one cycle of done/err, or it counts as a new request.
  - Parameter inputs are sampled only at grant; later changes have no effect on the running job.
- Latency: grant to core_start_o is 1 cycle; tag_valid to done_o is 1 cycle.
- Fairness: with both requesters continuously active, grants alternate 0,1,0,1.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done/err pulse. core_abort_o is not asserted; the core is reset by the same reset.

Test Plan:
- Reset, req_i=2'b01, core_ready_i=1 -> gnt_o=01 next cycle, core_start_o one pulse 1 cycle later, core_key_o=key0_i. Tag_valid with tag=128'hA5..A5 -> done_o=01 one cycle later, tag_o=A5..A5.
- req_i=2'b11 held, 4 jobs back-to-back -> gnt_o sequence 01,10,01,10; each start occurs only after core_ready_i=1.
- Grant to 1 with key1=K1, change key1_i mid-job -> core_key_o stays K1 until done.
- WdogCycles=16, never assert tag_valid -> core_abort_o and err_o[owner] pulse at start+16 cycles, done_o never set, returns to IDLE.
- tag_valid on the watchdog expiry cycle -> done_o pulses, err_o=0, core_abort_o=0.
- rst_i asserted while in BUSY -> next cycle all outputs 0; after reset, req_i=11 grants requester 0 first.

Source files
------------

// File: rtl/ascon_rr_sched_if.sv
// Bundle of requester, scheduler and core-side signals for ascon_rr_sched.
// master = requesters plus ascon_top integration, slave = the scheduler itself.
interface ascon_rr_sched_if #(
    parameter int DataAddrWidth = 7,
    parameter int DelayWidth    = 16
) ();
    // requester side
    logic [1:0]               req;
    logic [127:0]             key0;
    logic [127:0]             key1;
    logic [127:0]             nonce0;
    logic [127:0]             nonce1;
    logic [DataAddrWidth-1:0] ad_size0;
    logic [DataAddrWidth-1:0] ad_size1;
    logic [DataAddrWidth-1:0] pt_size0;
    logic [DataAddrWidth-1:0] pt_size1;
    logic [DelayWidth-1:0]    delay0;
    logic [DelayWidth-1:0]    delay1;
    logic [1:0]               gnt;
    logic [1:0]               done;
    logic [1:0]               err;
    logic [127:0]             tag;
    logic                     sel;

    // ascon_top side
    logic [127:0]             core_key;
    logic [127:0]             core_nonce;
    logic [DataAddrWidth-1:0] core_ad_size;
    logic [DataAddrWidth-1:0] core_pt_size;
    logic [DelayWidth-1:0]    core_delay;
    logic                     core_start;
    logic                     core_ready;
    logic                     core_tag_valid;
    logic [127:0]             core_tag;
    logic                     core_abort;

    modport master (
        output req, key0, key1, nonce0, nonce1,
               ad_size0, ad_size1, pt_size0, pt_size1, delay0, delay1,
               core_ready, core_tag_valid, core_tag,
        input  gnt, done, err, tag, sel,
               core_key, core_nonce, core_ad_size, core_pt_size, core_delay,
               core_start, core_abort
    );

    modport slave (
        input  req, key0, key1, nonce0, nonce1,
               ad_size0, ad_size1, pt_size0, pt_size1, delay0, delay1,
               core_ready, core_tag_valid, core_tag,
        output gnt, done, err, tag, sel,
               core_key, core_nonce, core_ad_size, core_pt_size, core_delay,
               core_start, core_abort
    );
endinterface

// File: rtl/ascon_rr_sched.sv
// Two-port round-robin scheduler sharing one ascon_top core, with a per-job
// watchdog that aborts the core if no tag arrives in time.
module ascon_rr_sched #(
    parameter int          DataAddrWidth = 7,
    parameter int          DelayWidth    = 16,
    parameter int          WdogWidth     = 20,
    parameter int unsigned WdogCycles    = 20'hFFFFF
) (
    input logic             clk_i,
    input logic             rst_i,
    ascon_rr_sched_if.slave bus
);
    localparam logic [WdogWidth-1:0] WDOG_LAST = WdogWidth'(WdogCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DONE,
        ABORT
    } state_t;

    state_t                   state_reg;
    logic                     last_reg;
    logic [WdogWidth-1:0]     wdog_reg;

    logic [1:0]               gnt_reg;
    logic [1:0]               done_reg;
    logic [1:0]               err_reg;
    logic [127:0]             tag_reg;
    logic                     sel_reg;
    logic [127:0]             key_reg;
    logic [127:0]             nonce_reg;
    logic [DataAddrWidth-1:0] ad_size_reg;
    logic [DataAddrWidth-1:0] pt_size_reg;
    logic [DelayWidth-1:0]    delay_reg;
    logic                     start_reg;
    logic                     abort_reg;

    // Per-requester parameter views, indexed by the arbitration winner.
    logic [127:0]             key_arr     [2];
    logic [127:0]             nonce_arr   [2];
    logic [DataAddrWidth-1:0] ad_size_arr [2];
    logic [DataAddrWidth-1:0] pt_size_arr [2];
    logic [DelayWidth-1:0]    delay_arr   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        if (gi == 0) begin : g_p0
            assign key_arr[gi]     = bus.key0;
            assign nonce_arr[gi]   = bus.nonce0;
            assign ad_size_arr[gi] = bus.ad_size0;
            assign pt_size_arr[gi] = bus.pt_size0;
            assign delay_arr[gi]   = bus.delay0;
        end else begin : g_p1
            assign key_arr[gi]     = bus.key1;
            assign nonce_arr[gi]   = bus.nonce1;
            assign ad_size_arr[gi] = bus.ad_size1;
            assign pt_size_arr[gi] = bus.pt_size1;
            assign delay_arr[gi]   = bus.delay1;
        end
    end

    // Contention goes to whoever was not served last; otherwise the sole requester.
    logic winner;
    always_comb begin
        winner = 1'b0;
        if (bus.req == 2'b11) begin
            winner = ~last_reg;
        end else begin
            winner = bus.req[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            wdog_reg    <= '0;
            gnt_reg     <= '0;
            done_reg    <= '0;
            err_reg     <= '0;
            tag_reg     <= '0;
            sel_reg     <= 1'b0;
            key_reg     <= '0;
            nonce_reg   <= '0;
            ad_size_reg <= '0;
            pt_size_reg <= '0;
            delay_reg   <= '0;
            start_reg   <= 1'b0;
            abort_reg   <= 1'b0;
        end else begin
            done_reg  <= '0;
            err_reg   <= '0;
            start_reg <= 1'b0;
            abort_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.core_ready && (bus.req != 2'b00)) begin
                        key_reg     <= key_arr[winner];
                        nonce_reg   <= nonce_arr[winner];
                        ad_size_reg <= ad_size_arr[winner];
                        pt_size_reg <= pt_size_arr[winner];
                        delay_reg   <= delay_arr[winner];
                        gnt_reg     <= {winner, ~winner};
                        sel_reg     <= winner;
                        last_reg    <= winner;
                        state_reg   <= START;
                    end
                end

                START: begin
                    start_reg <= 1'b1;
                    wdog_reg  <= '0;
                    state_reg <= BUSY;
                end

                BUSY: begin
                    wdog_reg <= wdog_reg + WdogWidth'(1);
                    // A tag arriving on the expiry cycle still completes the job.
                    if (bus.core_tag_valid) begin
                        tag_reg   <= bus.core_tag;
                        done_reg  <= {sel_reg, ~sel_reg};
                        state_reg <= DONE;
                    end else if (wdog_reg == WDOG_LAST) begin
                        abort_reg <= 1'b1;
                        err_reg   <= {sel_reg, ~sel_reg};
                        gnt_reg   <= '0;
                        state_reg <= ABORT;
                    end
                end

                DONE: begin
                    gnt_reg <= '0;
                    if (!bus.core_tag_valid && bus.core_ready) begin
                        state_reg <= IDLE;
                    end
                end

                ABORT: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_reg;
    assign bus.done         = done_reg;
    assign bus.err          = err_reg;
    assign bus.tag          = tag_reg;
    assign bus.sel          = sel_reg;
    assign bus.core_key     = key_reg;
    assign bus.core_nonce   = nonce_reg;
    assign bus.core_ad_size = ad_size_reg;
    assign bus.core_pt_size = pt_size_reg;
    assign bus.core_delay   = delay_reg;
    assign bus.core_start   = start_reg;
    assign bus.core_abort   = abort_reg;
endmodule

// File: tb/tb_ascon_rr_sched.sv
// Directed bench for ascon_rr_sched: grant/start/done timing, fairness,
// parameter hold, watchdog abort, tag-vs-expiry priority and mid-job reset.
module tb_ascon_rr_sched;
    localparam int          DAW = 7;
    localparam int          DW  = 16;
    localparam int          WW  = 20;
    localparam int unsigned WC  = 16;

    localparam logic [127:0] K0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1   = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] K1B  = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] N0   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] N1   = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] TA5  = {16{8'hA5}};
    localparam logic [127:0] T3C  = {16{8'h3C}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_rr_sched_if #(.DataAddrWidth(DAW), .DelayWidth(DW)) bus ();

    ascon_rr_sched #(
        .DataAddrWidth(DAW),
        .DelayWidth   (DW),
        .WdogWidth    (WW),
        .WdogCycles   (WC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.core_ready = 1'b1;
        bus.core_tag_valid = 1'b0;
        bus.core_tag = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.gnt, bus.done, bus.err, bus.sel, bus.core_start, bus.core_abort} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b sel=%b start=%b abort=%b, want all 0",
                     bus.gnt, bus.done, bus.err, bus.sel, bus.core_start, bus.core_abort);
        end
        checks++;
        if ({bus.tag, bus.core_key, bus.core_nonce} !== 384'd0) begin
            errors++;
            $display("FAIL reset_data: got tag=%h key=%h nonce=%h, want 0", bus.tag, bus.core_key, bus.core_nonce);
        end
        checks++;
        if ({bus.core_ad_size, bus.core_pt_size, bus.core_delay} !== '0) begin
            errors++;
            $display("FAIL reset_sizes: got ad=%0d pt=%0d delay=%0d, want 0",
                     bus.core_ad_size, bus.core_pt_size, bus.core_delay);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 2'b01;
        tick();
        checks++;
        if (bus.gnt !== 2'b01 || bus.sel !== 1'b0 || bus.core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b sel=%b start=%b, want 01 0 0", bus.gnt, bus.sel, bus.core_start);
        end
        checks++;
        if (bus.core_key !== K0 || bus.core_nonce !== N0 || bus.core_ad_size !== 7'd5 ||
            bus.core_pt_size !== 7'd9 || bus.core_delay !== 16'h0102) begin
            errors++;
            $display("FAIL single_params: got key=%h nonce=%h ad=%0d pt=%0d delay=%h",
                     bus.core_key, bus.core_nonce, bus.core_ad_size, bus.core_pt_size, bus.core_delay);
        end
        tick();
        checks++;
        if (bus.core_start !== 1'b1) begin
            errors++;
            $display("FAIL single_start: got start=%b, want 1", bus.core_start);
        end
        bus.core_ready = 1'b0;
        tick();
        checks++;
        if (bus.core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_pulse: got start=%b, want 0", bus.core_start);
        end
        tick();
        bus.core_tag = TA5;
        bus.core_tag_valid = 1'b1;
        tick();
        checks++;
        if (bus.done !== 2'b01 || bus.err !== 2'b00 || bus.tag !== TA5) begin
            errors++;
            $display("FAIL single_done: got done=%b err=%b tag=%h, want 01 00 %h", bus.done, bus.err, bus.tag, TA5);
        end
        bus.core_tag_valid = 1'b0;
        bus.core_ready = 1'b1;
        bus.req = 2'b00;
        tick();
        checks++;
        if (bus.done !== 2'b00 || bus.gnt !== 2'b00 || bus.tag !== TA5) begin
            errors++;
            $display("FAIL single_after: got done=%b gnt=%b tag=%h, want 00 00 %h", bus.done, bus.gnt, bus.tag, TA5);
        end
        $display("single: job on port 0 tag=%h", bus.tag);
    endtask

    // One job under continuous contention; the core holds ready low for a few idle cycles first.
    task automatic run_contended_job(input logic [1:0] exp_gnt, input logic [127:0] t, input int idx);
        bit got;
        bus.core_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        checks++;
        if (bus.gnt !== 2'b00 || bus.core_start !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wait_ready[%0d]: got gnt=%b start=%b, want 00 0", idx, bus.gnt, bus.core_start);
        end
        bus.core_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus.gnt != 2'b00) got = 1'b1;
        end
        checks++;
        if (!got || bus.gnt !== exp_gnt) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: got gnt=%b (seen=%0d), want %b", idx, bus.gnt, got, exp_gnt);
        end
        tick();
        checks++;
        if (bus.core_start !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start[%0d]: got start=%b, want 1", idx, bus.core_start);
        end
        bus.core_ready = 1'b0;
        tick();
        bus.core_tag = t;
        bus.core_tag_valid = 1'b1;
        tick();
        checks++;
        if (bus.done !== exp_gnt || bus.tag !== t) begin
            errors++;
            $display("FAIL b2b_done[%0d]: got done=%b tag=%h, want %b %h", idx, bus.done, bus.tag, exp_gnt, t);
        end
        bus.core_tag_valid = 1'b0;
        bus.core_ready = 1'b1;
        tick();
        $display("b2b: job %0d granted %b tag=%h", idx, exp_gnt, t);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 2'b11;
        run_contended_job(2'b01, TA5, 0);
        run_contended_job(2'b10, T3C, 1);
        run_contended_job(2'b01, K0, 2);
        run_contended_job(2'b10, K1, 3);
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_param_hold();
        do_reset();
        bus.key1 = K1;
        bus.req = 2'b10;
        tick();
        checks++;
        if (bus.gnt !== 2'b10 || bus.sel !== 1'b1 || bus.core_key !== K1 || bus.core_nonce !== N1) begin
            errors++;
            $display("FAIL hold_grant: got gnt=%b sel=%b key=%h nonce=%h", bus.gnt, bus.sel, bus.core_key, bus.core_nonce);
        end
        bus.key1 = K1B;
        bus.nonce1 = K1B;
        bus.delay1 = 16'hFFFF;
        tick();
        bus.core_ready = 1'b0;
        bus.req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        checks++;
        if (bus.core_key !== K1 || bus.core_nonce !== N1 || bus.core_delay !== 16'h0304 || bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL hold_mid: got key=%h nonce=%h delay=%h gnt=%b, want %h %h 0304 10",
                     bus.core_key, bus.core_nonce, bus.core_delay, bus.gnt, K1, N1);
        end
        bus.core_tag = T3C;
        bus.core_tag_valid = 1'b1;
        tick();
        checks++;
        if (bus.done !== 2'b10 || bus.core_key !== K1 || bus.tag !== T3C) begin
            errors++;
            $display("FAIL hold_done: got done=%b key=%h tag=%h, want 10 %h %h", bus.done, bus.core_key, bus.tag, K1, T3C);
        end
        bus.core_tag_valid = 1'b0;
        bus.core_ready = 1'b1;
        bus.key1 = K1;
        bus.nonce1 = N1;
        bus.delay1 = 16'h0304;
        tick();
        $display("hold: port 1 job key=%h", K1);
    endtask

    task automatic test_watchdog();
        bit early;
        do_reset();
        bus.req = 2'b01;
        tick();
        tick();
        bus.core_ready = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus.core_abort !== 1'b0 || bus.err !== 2'b00) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL wdog_early: got abort/err before start+16, want none");
        end
        tick();
        checks++;
        if (bus.core_abort !== 1'b1 || bus.err !== 2'b01 || bus.done !== 2'b00 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL wdog_abort: got abort=%b err=%b done=%b gnt=%b, want 1 01 00 00",
                     bus.core_abort, bus.err, bus.done, bus.gnt);
        end
        bus.req = 2'b00;
        bus.core_ready = 1'b1;
        tick();
        checks++;
        if (bus.core_abort !== 1'b0 || bus.err !== 2'b00 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL wdog_pulse: got abort=%b err=%b done=%b, want 0 00 00", bus.core_abort, bus.err, bus.done);
        end
        bus.req = 2'b10;
        tick();
        checks++;
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL wdog_idle: got gnt=%b after abort, want 10", bus.gnt);
        end
        tick();
        bus.core_ready = 1'b0;
        bus.req = 2'b00;
        tick();
        bus.core_tag = K0;
        bus.core_tag_valid = 1'b1;
        tick();
        bus.core_tag_valid = 1'b0;
        bus.core_ready = 1'b1;
        tick();
        $display("wdog: abort at start+16 on port 0");
    endtask

    task automatic test_coincide();
        do_reset();
        bus.req = 2'b01;
        tick();
        tick();
        bus.core_ready = 1'b0;
        bus.req = 2'b00;
        for (int k = 1; k <= 15; k++) begin
            tick();
        end
        bus.core_tag = T3C;
        bus.core_tag_valid = 1'b1;
        tick();
        checks++;
        if (bus.done !== 2'b01 || bus.err !== 2'b00 || bus.core_abort !== 1'b0 || bus.tag !== T3C) begin
            errors++;
            $display("FAIL coincide: got done=%b err=%b abort=%b tag=%h, want 01 00 0 %h",
                     bus.done, bus.err, bus.core_abort, bus.tag, T3C);
        end
        bus.core_tag_valid = 1'b0;
        bus.core_ready = 1'b1;
        tick();
        checks++;
        if (bus.err !== 2'b00 || bus.core_abort !== 1'b0) begin
            errors++;
            $display("FAIL coincide_after: got err=%b abort=%b, want 00 0", bus.err, bus.core_abort);
        end
        $display("coincide: tag on expiry cycle completed");
    endtask

    task automatic test_reset_busy();
        do_reset();
        bus.req = 2'b01;
        tick();
        tick();
        bus.core_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.gnt, bus.done, bus.err, bus.core_start, bus.core_abort} !== 8'd0 || bus.core_key !== '0) begin
            errors++;
            $display("FAIL rst_busy: got gnt=%b done=%b err=%b start=%b abort=%b key=%h, want all 0",
                     bus.gnt, bus.done, bus.err, bus.core_start, bus.core_abort, bus.core_key);
        end
        rst = 1'b0;
        bus.req = 2'b11;
        bus.core_ready = 1'b1;
        tick();
        checks++;
        if (bus.gnt !== 2'b01 || bus.core_key !== K0) begin
            errors++;
            $display("FAIL rst_priority: got gnt=%b key=%h, want 01 %h", bus.gnt, bus.core_key, K0);
        end
        $display("rst_busy: requester 0 first after reset");
    endtask

    initial begin
        bus.req = 2'b00;
        bus.key0 = K0;
        bus.key1 = K1;
        bus.nonce0 = N0;
        bus.nonce1 = N1;
        bus.ad_size0 = 7'd5;
        bus.ad_size1 = 7'd17;
        bus.pt_size0 = 7'd9;
        bus.pt_size1 = 7'd33;
        bus.delay0 = 16'h0102;
        bus.delay1 = 16'h0304;
        bus.core_ready = 1'b1;
        bus.core_tag_valid = 1'b0;
        bus.core_tag = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_param_hold();
        test_watchdog();
        test_coincide();
        test_reset_busy();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
